// File: rtl/input_pref_ctrl_pkg.sv
// Shared types and constants for the input prefetcher sequencing controller.
package pref_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_IBUF = 2'b01,
        MODE_CUT  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int LAT_IBUF = 1;
    localparam int LAT_CUT  = 2;

    function automatic mode_e path_mode(input logic cut);
        return cut ? MODE_CUT : MODE_IBUF;
    endfunction

endpackage

// File: rtl/input_pref_ctrl_if.sv
// Tile request, SA back-pressure and prefetcher control bundle.
interface input_pref_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             src_sel;
    logic [CNT_W-1:0] tile_len;
    logic             sa_ready;
    logic             rd_en;
    logic [CNT_W-1:0] rd_addr;
    logic             en_cutting0;
    logic [1:0]       mode_selector;
    logic             en;
    logic             buf_select;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, src_sel, tile_len, sa_ready,
        input  rd_en, rd_addr, en_cutting0, mode_selector, en,
               buf_select, valid, busy, done
    );

    modport slave (
        input  start, src_sel, tile_len, sa_ready,
        output rd_en, rd_addr, en_cutting0, mode_selector, en,
               buf_select, valid, busy, done
    );
endinterface

// File: rtl/input_pref_ctrl_valid_pipe.sv
// Tracks in-flight source reads through the optional cutting register and
// produces the register enables and the output valid strobe.
module pref_valid_pipe
    import pref_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic issue,
    input  logic sa_ready,
    input  logic cut,
    output logic en_cutting0,
    output logic en,
    output logic valid,
    output logic in_flight
);

    logic [LAT_CUT-1:0] stage_v;
    logic               final_v;

    // Whole pipe freezes on a global stall; stage 1 only fills on the cutting path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_v <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= en;
            if (sa_ready) begin
                stage_v[0] <= issue;
                stage_v[1] <= cut & stage_v[0];
            end
        end
    end

    assign final_v     = cut ? stage_v[LAT_CUT-1] : stage_v[LAT_IBUF-1];
    assign en_cutting0 = cut & stage_v[0] & sa_ready;
    assign en          = final_v & sa_ready;
    assign in_flight   = |stage_v;

endmodule

// File: rtl/input_pref_ctrl.sv
// Input prefetcher sequencer: latches the tile source, issues buffer reads
// and owns the output-buffer ping-pong bit.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ISSUE | issuing read addresses 0..tile_len-1 while sa_ready
// ST_DRAIN | all reads issued, waiting for the valid pipe to empty
// ST_DONE  | one-cycle completion pulse, ping-pong update
module input_pref_ctrl
    import pref_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input_pref_ctrl_if.slave  bus
);

    // Data width is carried for the surrounding prefetcher only.
    if (N <= 0) begin : g_bad_width
    end

    state_e           state, state_nxt;
    logic             src_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] addr_q;
    logic             buf_q;
    logic             accept;
    logic             rd_en;
    logic             last_issue;
    logic             in_flight;
    logic             en_cutting0;
    logic             en;
    logic             valid;

    assign accept     = (state == ST_IDLE) && bus.start;
    assign rd_en      = (state == ST_ISSUE) && bus.sa_ready;
    assign last_issue = rd_en && (addr_q == len_q - CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = (bus.tile_len == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (last_issue) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!in_flight) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy          = (state == ST_ISSUE) || (state == ST_DRAIN);
        bus.done          = (state == ST_DONE);
        bus.mode_selector = bus.busy ? path_mode(src_q) : MODE_IDLE;
    end

    // Address stops on the last read so it can never wrap within a tile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= 1'b0;
            len_q  <= '0;
            addr_q <= '0;
            buf_q  <= 1'b0;
        end else begin
            if (accept) begin
                src_q  <= bus.src_sel;
                len_q  <= bus.tile_len;
                addr_q <= '0;
            end else if (rd_en && !last_issue) begin
                addr_q <= addr_q + CNT_W'(1);
            end
            if ((state == ST_DONE) && src_q) begin
                buf_q <= ~buf_q;
            end
        end
    end

    pref_valid_pipe u_valid_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue       (rd_en),
        .sa_ready    (bus.sa_ready),
        .cut         (src_q),
        .en_cutting0 (en_cutting0),
        .en          (en),
        .valid       (valid),
        .in_flight   (in_flight)
    );

    assign bus.rd_en       = rd_en;
    assign bus.rd_addr     = addr_q;
    assign bus.en_cutting0 = en_cutting0;
    assign bus.en          = en;
    assign bus.valid       = valid;
    assign bus.buf_select  = buf_q;

endmodule
